// File: rtl/codec_pkg.sv
// codec_pkg: shared widths, clock dividers and responder state encoding
package codec_pkg;
  localparam int DATA_W_DFLT = 16;
  localparam int LRCLK_DIV = 1024;
  localparam int SCLK_DIV = 32;
  localparam int MCLK_DIV = 4;
  typedef enum logic [1:0] {IDLE, ALIGN, LEFT, RIGHT} codec_state_t;
endpackage

// File: rtl/codec_responder_edge_sync.sv
// edge_sync: two-flop synchronizer with rise/fall pulses formed from both stages
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);
  logic s1_q, s2_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end
  assign q_o = s2_q;
  assign rise_o = s1_q & ~s2_q;
  assign fall_o = ~s1_q & s2_q;
endmodule

// File: rtl/codec_responder.sv
// codec_responder: codec-side serial port, SD_in -> DAC words, ADC words -> SD_out
module codec_responder
  import codec_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT,
  parameter int MCLK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              LRCLK,
  input  logic              SCLK,
  input  logic              MCLK,
  input  logic              RST_n,
  input  logic              SD_in,
  input  logic [DATA_W-1:0] adc_left,
  input  logic [DATA_W-1:0] adc_right,
  output logic              SD_out,
  output logic [DATA_W-1:0] dac_left,
  output logic [DATA_W-1:0] dac_right,
  output logic              dac_valid,
  output logic              frame_err
);
  localparam int CW = $clog2(DATA_W + 1);
  localparam int MW = $clog2(MCLK_TIMEOUT + 1);
  logic lr_rise, lr_fall, sc_rise, sc_fall, mc_rise, mc_fall, sd_s;
  logic lr_unused, sc_unused, mc_unused, sd_unused_rise, sd_unused_fall;
  logic [1:0] rstn_q;
  logic [MW-1:0] mclk_cnt_q;
  codec_state_t state_q;
  logic [DATA_W-1:0] tx_sr_q, rx_sr_q;
  logic [CW-1:0] bit_cnt_q;
  logic left_ok_q, done_q, commit_l_q, commit_r_q;
  logic mclk_ok, active, in_frame, lr_edge, full;
  edge_sync u_lr (.clk, .rst, .d_i(LRCLK), .q_o(lr_unused), .rise_o(lr_rise), .fall_o(lr_fall));
  edge_sync u_sc (.clk, .rst, .d_i(SCLK), .q_o(sc_unused), .rise_o(sc_rise), .fall_o(sc_fall));
  edge_sync u_mc (.clk, .rst, .d_i(MCLK), .q_o(mc_unused), .rise_o(mc_rise), .fall_o(mc_fall));
  edge_sync u_sd (.clk, .rst, .d_i(SD_in), .q_o(sd_s), .rise_o(sd_unused_rise), .fall_o(sd_unused_fall));
  assign mclk_ok = mclk_cnt_q < MW'(MCLK_TIMEOUT);
  assign active = rstn_q[1] & mclk_ok;
  assign in_frame = (state_q == LEFT) || (state_q == RIGHT);
  assign lr_edge = lr_rise | lr_fall;
  assign full = bit_cnt_q == CW'(DATA_W);
  // Completed words are committed one cycle after bit_cnt fills, then latched.
  always_ff @(posedge clk) begin
    if (rst) begin
      rstn_q <= '0;
      mclk_cnt_q <= '0;
      state_q <= IDLE;
      tx_sr_q <= '0;
      rx_sr_q <= '0;
      bit_cnt_q <= '0;
      left_ok_q <= 1'b0;
      done_q <= 1'b0;
      commit_l_q <= 1'b0;
      commit_r_q <= 1'b0;
      SD_out <= 1'b0;
      dac_left <= '0;
      dac_right <= '0;
      dac_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rstn_q <= {rstn_q[0], RST_n};
      mclk_cnt_q <= (mc_rise | mc_fall) ? '0 : mclk_cnt_q + MW'(mclk_ok);
      dac_valid <= 1'b0;
      commit_l_q <= 1'b0;
      commit_r_q <= 1'b0;
      if (commit_l_q && active) dac_left <= rx_sr_q;
      if (commit_r_q && active) begin
        dac_right <= rx_sr_q;
        dac_valid <= left_ok_q;
      end
      if (!active) begin
        state_q <= IDLE;
        tx_sr_q <= '0;
        SD_out <= 1'b0;
        bit_cnt_q <= '0;
        left_ok_q <= 1'b0;
        done_q <= 1'b0;
      end else begin
        SD_out <= tx_sr_q[DATA_W-1];
        if (state_q == IDLE) state_q <= ALIGN;
        else if (lr_rise) begin
          state_q <= LEFT;
          tx_sr_q <= adc_left;
        end else if (lr_fall && in_frame) begin
          state_q <= RIGHT;
          tx_sr_q <= adc_right;
        end else if (sc_fall && in_frame) tx_sr_q <= {tx_sr_q[DATA_W-2:0], 1'b0};
        if (commit_l_q) left_ok_q <= 1'b1;
        if (lr_edge) begin
          bit_cnt_q <= '0;
          done_q <= 1'b0;
          if (in_frame && !full) frame_err <= 1'b1;
          if (lr_rise) left_ok_q <= 1'b0;
        end else if (in_frame && sc_rise) begin
          if (full) frame_err <= 1'b1;
          else begin
            rx_sr_q <= {rx_sr_q[DATA_W-2:0], sd_s};
            bit_cnt_q <= bit_cnt_q + CW'(1);
          end
        end
        if (in_frame && full && !done_q && !lr_edge) begin
          done_q <= 1'b1;
          commit_l_q <= state_q == LEFT;
          commit_r_q <= state_q == RIGHT;
        end
      end
    end
  end
endmodule

// File: tb/tb_codec_responder.sv
// tb_codec_responder: directed master-side scenarios with hand-computed expectations
`timescale 1ns/1ps
module tb_codec_responder;
  import codec_pkg::*;
  logic clk = 1'b0, rst = 1'b1, LRCLK = 1'b0, SCLK = 1'b1, MCLK = 1'b0, RST_n = 1'b1, SD_in = 1'b0;
  logic mclk_en = 1'b1;
  logic [15:0] adc_left = '0, adc_right = '0;
  logic SD_out, dac_valid, frame_err;
  logic [15:0] dac_left, dac_right;
  int n_chk = 0, n_pass = 0, vcnt = 0;
  codec_responder dut (
    .clk(clk), .rst(rst), .LRCLK(LRCLK), .SCLK(SCLK), .MCLK(MCLK), .RST_n(RST_n), .SD_in(SD_in),
    .adc_left(adc_left), .adc_right(adc_right), .SD_out(SD_out), .dac_left(dac_left),
    .dac_right(dac_right), .dac_valid(dac_valid), .frame_err(frame_err)
  );
  always #10 clk = ~clk;
  initial forever begin
    repeat (MCLK_DIV / 2) @(negedge clk);
    if (mclk_en) MCLK = ~MCLK;
  end
  always @(negedge clk) if (dac_valid === 1'b1) vcnt++;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic phase(input logic lr, input logic [15:0] w, input int n, input bit chk_load,
                       output logic [15:0] got);
    logic [15:0] sh;
    sh = w;
    got = '0;
    LRCLK = lr;
    for (int i = 0; i < n; i++) begin
      SCLK = 1'b0;
      SD_in = sh[15];
      sh = sh << 1;
      if (i == 0 && chk_load) begin
        repeat (2) @(negedge clk);
        n_chk++;
        if (dut.tx_sr_q !== (lr ? adc_left : adc_right))
          $display("FAIL load_wins: tx_sr=%h want %h", dut.tx_sr_q, lr ? adc_left : adc_right);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (SD_out !== (lr ? adc_left[15] : adc_right[15]))
          $display("FAIL first_bit: SD_out=%b want %b", SD_out, lr ? adc_left[15] : adc_right[15]);
        else n_pass++;
        repeat (13) @(negedge clk);
      end else repeat (16) @(negedge clk);
      SCLK = 1'b1;
      got = {got[14:0], SD_out};
      repeat (16) @(negedge clk);
    end
  endtask

  task automatic frame(input logic [15:0] al, ar, sl, sr, input bit chk_load,
                       output logic [15:0] gl, gr);
    adc_left = al;
    adc_right = ar;
    phase(1'b1, sl, 16, chk_load, gl);
    phase(1'b0, sr, 16, chk_load, gr);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (SD_out !== 1'b0) $display("FAIL reset_sd_out: got %b want 0", SD_out); else n_pass++;
    n_chk++; if (dac_left !== 16'h0) $display("FAIL reset_dac_left: got %h want 0000", dac_left); else n_pass++;
    n_chk++; if (dac_right !== 16'h0) $display("FAIL reset_dac_right: got %h want 0000", dac_right); else n_pass++;
    n_chk++; if (dac_valid !== 1'b0) $display("FAIL reset_dac_valid: got %b want 0", dac_valid); else n_pass++;
    n_chk++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", frame_err); else n_pass++;
    n_chk++; if (dut.state_q !== IDLE) $display("FAIL reset_state: got %0d want IDLE", dut.state_q); else n_pass++;
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_nominal;
    int v0;
    logic [15:0] gl, gr;
    v0 = vcnt;
    frame(16'hA5C3, 16'h1234, 16'hBEEF, 16'h0F0F, 1'b1, gl, gr);
    n_chk++; if (gl !== 16'hA5C3) $display("FAIL nom_tx_left: got %h want a5c3", gl); else n_pass++;
    n_chk++; if (gr !== 16'h1234) $display("FAIL nom_tx_right: got %h want 1234", gr); else n_pass++;
    n_chk++; if (dac_left !== 16'hBEEF) $display("FAIL nom_dac_left: got %h want beef", dac_left); else n_pass++;
    n_chk++; if (dac_right !== 16'h0F0F) $display("FAIL nom_dac_right: got %h want 0f0f", dac_right); else n_pass++;
    n_chk++; if (vcnt !== v0 + 1) $display("FAIL nom_valid1: got %0d want %0d", vcnt - v0, 1); else n_pass++;
    frame(16'h8001, 16'h7FFE, 16'h1357, 16'hFEDC, 1'b0, gl, gr);
    n_chk++; if (gl !== 16'h8001) $display("FAIL nom2_tx_left: got %h want 8001", gl); else n_pass++;
    n_chk++; if (gr !== 16'h7FFE) $display("FAIL nom2_tx_right: got %h want 7ffe", gr); else n_pass++;
    n_chk++; if (dac_left !== 16'h1357) $display("FAIL nom2_dac_left: got %h want 1357", dac_left); else n_pass++;
    n_chk++; if (dac_right !== 16'hFEDC) $display("FAIL nom2_dac_right: got %h want fedc", dac_right); else n_pass++;
    n_chk++; if (vcnt !== v0 + 2) $display("FAIL nom_valid2: got %0d want %0d", vcnt - v0, 2); else n_pass++;
    n_chk++; if (frame_err !== 1'b0) $display("FAIL nom_frame_err: got %b want 0", frame_err); else n_pass++;
  endtask

  task automatic test_coincident;
    logic [15:0] gl, gr;
    frame(16'h8000, 16'h0001, 16'h0001, 16'h8000, 1'b1, gl, gr);
    n_chk++; if (gl !== 16'h8000) $display("FAIL coin_tx_left: got %h want 8000", gl); else n_pass++;
    n_chk++; if (gr !== 16'h0001) $display("FAIL coin_tx_right: got %h want 0001", gr); else n_pass++;
    n_chk++; if (dac_left !== 16'h0001) $display("FAIL coin_dac_left: got %h want 0001", dac_left); else n_pass++;
    n_chk++; if (dac_right !== 16'h8000) $display("FAIL coin_dac_right: got %h want 8000", dac_right); else n_pass++;
  endtask

  task automatic test_short_phase;
    int v0;
    logic [15:0] gl, gr;
    v0 = vcnt;
    phase(1'b1, 16'hDEAD, 15, 1'b0, gl);
    phase(1'b0, 16'hCAFE, 16, 1'b0, gr);
    n_chk++; if (frame_err !== 1'b1) $display("FAIL short_err: got %b want 1", frame_err); else n_pass++;
    n_chk++; if (dac_left !== 16'h0001) $display("FAIL short_no_latch: got %h want 0001", dac_left); else n_pass++;
    n_chk++; if (vcnt !== v0) $display("FAIL short_no_valid: got %0d want 0", vcnt - v0); else n_pass++;
    frame(16'hA5C3, 16'h1234, 16'h2468, 16'h1357, 1'b0, gl, gr);
    n_chk++; if (frame_err !== 1'b1) $display("FAIL short_sticky: got %b want 1", frame_err); else n_pass++;
    n_chk++; if (vcnt !== v0 + 1) $display("FAIL short_resume_valid: got %0d want 1", vcnt - v0); else n_pass++;
    n_chk++; if (dac_left !== 16'h2468) $display("FAIL short_resume_left: got %h want 2468", dac_left); else n_pass++;
  endtask

  task automatic test_rst_mid_left;
    logic [15:0] gl;
    adc_left = 16'hA5C3;
    phase(1'b1, 16'h1111, 8, 1'b0, gl);
    rst = 1'b1;
    @(negedge clk);
    n_chk++; if (SD_out !== 1'b0) $display("FAIL rst_sd_out: got %b want 0", SD_out); else n_pass++;
    n_chk++; if (dac_left !== 16'h0) $display("FAIL rst_dac_left: got %h want 0000", dac_left); else n_pass++;
    n_chk++; if (dac_right !== 16'h0) $display("FAIL rst_dac_right: got %h want 0000", dac_right); else n_pass++;
    n_chk++; if (dac_valid !== 1'b0) $display("FAIL rst_dac_valid: got %b want 0", dac_valid); else n_pass++;
    n_chk++; if (frame_err !== 1'b0) $display("FAIL rst_frame_err: got %b want 0", frame_err); else n_pass++;
    n_chk++; if (dut.state_q !== IDLE) $display("FAIL rst_state: got %0d want IDLE", dut.state_q); else n_pass++;
    rst = 1'b0;
    LRCLK = 1'b0;
    SCLK = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  task automatic test_overflow;
    logic [15:0] gl, gr;
    adc_left = 16'hA5C3;
    adc_right = 16'h1234;
    phase(1'b1, 16'h4321, 17, 1'b0, gl);
    phase(1'b0, 16'h8765, 16, 1'b0, gr);
    n_chk++; if (frame_err !== 1'b1) $display("FAIL ovf_err: got %b want 1", frame_err); else n_pass++;
    n_chk++; if (dac_right !== 16'h8765) $display("FAIL ovf_dac_right: got %h want 8765", dac_right); else n_pass++;
  endtask

  task automatic test_codec_reset;
    int v0;
    logic [15:0] gl, gr;
    v0 = vcnt;
    adc_left = 16'hA5C3;
    adc_right = 16'h1234;
    RST_n = 1'b0;
    for (int f = 0; f < 3; f++) begin
      phase(1'b1, 16'h1111, 16, 1'b0, gl);
      phase(1'b0, 16'h2222, 16, 1'b0, gr);
      n_chk++; if ({gl, gr} !== 32'h0) $display("FAIL creset_sd_out: got %h want 00000000", {gl, gr}); else n_pass++;
    end
    n_chk++; if (dut.state_q !== IDLE) $display("FAIL creset_state: got %0d want IDLE", dut.state_q); else n_pass++;
    n_chk++; if (dac_right !== 16'h8765) $display("FAIL creset_hold: got %h want 8765", dac_right); else n_pass++;
    phase(1'b1, 16'h1111, 16, 1'b0, gl);
    phase(1'b0, 16'h2222, 8, 1'b0, gr);
    RST_n = 1'b1;
    phase(1'b0, 16'h2222, 8, 1'b0, gr);
    n_chk++; if (vcnt !== v0) $display("FAIL creset_no_valid: got %0d want 0", vcnt - v0); else n_pass++;
    n_chk++; if (dut.state_q !== ALIGN) $display("FAIL creset_align: got %0d want ALIGN", dut.state_q); else n_pass++;
    frame(16'hA5C3, 16'h1234, 16'hC0DE, 16'hF00D, 1'b0, gl, gr);
    n_chk++; if (vcnt !== v0 + 1) $display("FAIL creset_valid: got %0d want 1", vcnt - v0); else n_pass++;
    n_chk++; if (dac_left !== 16'hC0DE) $display("FAIL creset_dac_left: got %h want c0de", dac_left); else n_pass++;
    n_chk++; if (dac_right !== 16'hF00D) $display("FAIL creset_dac_right: got %h want f00d", dac_right); else n_pass++;
    n_chk++; if (gl !== 16'hA5C3) $display("FAIL creset_tx_left: got %h want a5c3", gl); else n_pass++;
  endtask

  task automatic test_mclk_loss;
    int v0;
    logic [15:0] gl, gr;
    v0 = vcnt;
    adc_left = 16'hFFFF;
    phase(1'b1, 16'h3333, 4, 1'b0, gl);
    mclk_en = 1'b0;
    repeat (14) @(negedge clk);
    n_chk++; if (dut.state_q !== LEFT) $display("FAIL mclk_early: got %0d want LEFT", dut.state_q); else n_pass++;
    repeat (6) @(negedge clk);
    n_chk++; if (dut.state_q !== IDLE) $display("FAIL mclk_idle: got %0d want IDLE", dut.state_q); else n_pass++;
    n_chk++; if (SD_out !== 1'b0) $display("FAIL mclk_sd_out: got %b want 0", SD_out); else n_pass++;
    mclk_en = 1'b1;
    phase(1'b1, 16'h3333, 12, 1'b0, gl);
    phase(1'b0, 16'h4444, 16, 1'b0, gr);
    n_chk++; if (vcnt !== v0) $display("FAIL mclk_no_valid: got %0d want 0", vcnt - v0); else n_pass++;
    n_chk++; if (dac_left !== 16'hC0DE) $display("FAIL mclk_hold: got %h want c0de", dac_left); else n_pass++;
    frame(16'hA5C3, 16'h1234, 16'h5555, 16'hAAAA, 1'b0, gl, gr);
    n_chk++; if (vcnt !== v0 + 1) $display("FAIL mclk_valid: got %0d want 1", vcnt - v0); else n_pass++;
    n_chk++; if (dac_left !== 16'h5555) $display("FAIL mclk_dac_left: got %h want 5555", dac_left); else n_pass++;
    n_chk++; if (dac_right !== 16'hAAAA) $display("FAIL mclk_dac_right: got %h want aaaa", dac_right); else n_pass++;
    n_chk++; if (gr !== 16'h1234) $display("FAIL mclk_tx_right: got %h want 1234", gr); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_coincident;
    test_short_phase;
    test_rst_mid_left;
    test_overflow;
    test_codec_reset;
    test_mclk_loss;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
